// File: rtl/mshr_file_if.sv
// Request, memory and fill signals of the miss-status holding register file.
// The slave modport is the MSHR file itself; the master modport is the
// cache/memory side that drives requests and memory responses.
interface mshr_file_if #(
    parameter int LQ_IDX_W = 3,
    parameter int ADDR_W   = 64
);
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_is_icache;
    logic [LQ_IDX_W-1:0] req_lq_idx;
    logic                req_grant;
    logic                branch_recovery;
    logic [3:0]          mem2proc_response;
    logic [3:0]          mem2proc_tag;
    logic [63:0]         mem2proc_data;
    logic [1:0]          proc2mem_command;
    logic [ADDR_W-1:0]   proc2mem_addr;
    logic                fill_valid;
    logic [ADDR_W-1:0]   fill_addr;
    logic [63:0]         fill_data;
    logic                fill_is_icache;
    logic                fill_lq_valid;
    logic [LQ_IDX_W-1:0] fill_lq_idx;
    logic                mshr_full;

    modport slave (
        input  req_valid, req_addr, req_is_icache, req_lq_idx, branch_recovery,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        output req_grant, proc2mem_command, proc2mem_addr, fill_valid, fill_addr,
               fill_data, fill_is_icache, fill_lq_valid, fill_lq_idx, mshr_full
    );

    modport master (
        output req_valid, req_addr, req_is_icache, req_lq_idx, branch_recovery,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        input  req_grant, proc2mem_command, proc2mem_addr, fill_valid, fill_addr,
               fill_data, fill_is_icache, fill_lq_valid, fill_lq_idx, mshr_full
    );
endinterface

// File: rtl/mshr_file.sv
// Miss-status holding register file shared by I-cache fills and D-cache loads.
// Each entry walks INVALID -> ISSUE -> WAIT -> DONE -> INVALID.
//
// state   | meaning
// INVALID | entry free
// ISSUE   | waiting for memory to accept the LOAD
// WAIT    | accepted, waiting for the returning tag
// DONE    | data captured, waiting to be presented as a fill
//
// Optional feature: define MSHR_MERGE_EN to let a new miss to a block that
// already has a WAIT entry piggyback on that entry's memory tag.
module mshr_file #(
    parameter int NUM_ENTRIES = 4,
    parameter int LQ_IDX_W    = 3,
    parameter int ADDR_W      = 64
) (
    input logic        clock,
    input logic        reset,
    mshr_file_if.slave bus
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {INVALID, ISSUE, WAIT, DONE} ent_state_e;

    ent_state_e          st_q       [NUM_ENTRIES];
    logic [ADDR_W-1:0]   addr_q     [NUM_ENTRIES];
    logic                icache_q   [NUM_ENTRIES];
    logic [LQ_IDX_W-1:0] lq_idx_q   [NUM_ENTRIES];
    logic                squashed_q [NUM_ENTRIES];
    logic [3:0]          tag_q      [NUM_ENTRIES];
    logic [63:0]         data_q     [NUM_ENTRIES];

    logic              alloc_found, issue_found, fill_found;
    logic [IDX_W-1:0]  alloc_idx, issue_idx, fill_idx;
    logic              grant;
    logic              merge_hit, merge_done;
    logic [3:0]        merge_tag;
    logic [ADDR_W-1:0] req_block;

    assign req_block = {bus.req_addr[ADDR_W-1:3], 3'b000};

    // Priority pickers: lowest free, lowest issuing and lowest completed entry.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        fill_found  = 1'b0;
        fill_idx    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!alloc_found && st_q[i] == INVALID) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (!issue_found && st_q[i] == ISSUE) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!fill_found && st_q[i] == DONE) begin
                fill_found = 1'b1;
                fill_idx   = IDX_W'(i);
            end
        end
    end

    // Merge lookup against entries already waiting on memory.
    always_comb begin
        merge_hit  = 1'b0;
        merge_tag  = 4'd0;
        merge_done = 1'b0;
`ifdef MSHR_MERGE_EN
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!merge_hit && st_q[i] == WAIT && addr_q[i] == req_block) begin
                merge_hit = 1'b1;
                merge_tag = tag_q[i];
            end
        end
        // Data for the shared tag arriving right now must not be missed.
        merge_done = merge_hit && (bus.mem2proc_tag != 4'd0) && (bus.mem2proc_tag == merge_tag);
`endif
    end

    // Request handshake plus memory-request and fill output drive.
    always_comb begin
        grant = bus.req_valid & alloc_found & ~(bus.branch_recovery & ~bus.req_is_icache) & ~reset;
        bus.req_grant        = grant;
        bus.mshr_full        = ~alloc_found;
        bus.proc2mem_command = issue_found ? 2'd1 : 2'd0;
        bus.proc2mem_addr    = issue_found ? addr_q[issue_idx] : '0;
        bus.fill_valid       = fill_found;
        bus.fill_addr        = fill_found ? addr_q[fill_idx] : '0;
        bus.fill_data        = fill_found ? data_q[fill_idx] : '0;
        bus.fill_is_icache   = fill_found ? icache_q[fill_idx] : 1'b0;
        bus.fill_lq_idx      = fill_found ? lq_idx_q[fill_idx] : '0;
        bus.fill_lq_valid    = fill_found & ~icache_q[fill_idx] & ~squashed_q[fill_idx];
    end

    // Per-entry state advance; a squash frees an unissued D-load outright.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                st_q[i]       <= INVALID;
                addr_q[i]     <= '0;
                icache_q[i]   <= 1'b0;
                lq_idx_q[i]   <= '0;
                squashed_q[i] <= 1'b0;
                tag_q[i]      <= 4'd0;
                data_q[i]     <= 64'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                case (st_q[i])
                    ISSUE: begin
                        if (bus.branch_recovery && !icache_q[i]) begin
                            st_q[i] <= INVALID;
                        end else if (issue_idx == IDX_W'(i) && bus.mem2proc_response != 4'd0) begin
                            tag_q[i] <= bus.mem2proc_response;
                            st_q[i]  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem2proc_tag != 4'd0 && tag_q[i] == bus.mem2proc_tag) begin
                            data_q[i] <= bus.mem2proc_data;
                            st_q[i]   <= DONE;
                        end
                        if (bus.branch_recovery && !icache_q[i]) squashed_q[i] <= 1'b1;
                    end
                    DONE: begin
                        if (fill_idx == IDX_W'(i)) st_q[i] <= INVALID;
                        if (bus.branch_recovery && !icache_q[i]) squashed_q[i] <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (grant) begin
                st_q[alloc_idx]       <= merge_done ? DONE : (merge_hit ? WAIT : ISSUE);
                addr_q[alloc_idx]     <= req_block;
                icache_q[alloc_idx]   <= bus.req_is_icache;
                lq_idx_q[alloc_idx]   <= bus.req_lq_idx;
                squashed_q[alloc_idx] <= 1'b0;
                tag_q[alloc_idx]      <= merge_tag;
                data_q[alloc_idx]     <= bus.mem2proc_data;
            end
        end
    end
endmodule
